// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcode, ALUOp and writeback-select encodings plus the control bundle shared by the control pipeline.
package ctrl_pkg;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_BR  = 2'b01;
  localparam logic [1:0] ALU_R   = 2'b10;
  localparam logic [1:0] ALU_I   = 2'b11;
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] WB_IMM = 2'b11;
  typedef struct packed {
    logic       valid;
    logic       regwrite;
    logic       alusrc;
    logic       branch;
    logic       jump;
    logic       memread;
    logic       memwrite;
    logic       illegal;
    logic [1:0] aluop;
    logic [1:0] wb_sel;
  } ctrl_bundle_t;
  localparam ctrl_bundle_t BUBBLE = '0;
endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational opcode-to-bundle decoder with source-register usage flags.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [6:0]            opcode,
  input  logic [REG_ADDR_W-1:0] rd,
  output ctrl_bundle_t          ctrl,
  output logic                  rs1_used,
  output logic                  rs2_used
);
  always_comb begin
    ctrl = BUBBLE;
    ctrl.valid = 1'b1;
    rs1_used = 1'b1;
    rs2_used = 1'b0;
    case (opcode)
      OP_R:      begin ctrl.regwrite = 1'b1; ctrl.aluop = ALU_R; rs2_used = 1'b1; end
      OP_I:      begin ctrl.regwrite = 1'b1; ctrl.alusrc = 1'b1; ctrl.aluop = ALU_I; end
      OP_LOAD:   begin ctrl.regwrite = 1'b1; ctrl.alusrc = 1'b1; ctrl.memread = 1'b1; ctrl.wb_sel = WB_MEM; end
      OP_STORE:  begin ctrl.alusrc = 1'b1; ctrl.memwrite = 1'b1; rs2_used = 1'b1; end
      OP_BRANCH: begin ctrl.branch = 1'b1; ctrl.aluop = ALU_BR; rs2_used = 1'b1; end
      OP_JAL:    begin ctrl.regwrite = 1'b1; ctrl.jump = 1'b1; ctrl.wb_sel = WB_PC4; rs1_used = 1'b0; end
      OP_JALR:   begin ctrl.regwrite = 1'b1; ctrl.jump = 1'b1; ctrl.alusrc = 1'b1; ctrl.wb_sel = WB_PC4; end
      OP_LUI:    begin ctrl.regwrite = 1'b1; ctrl.alusrc = 1'b1; ctrl.wb_sel = WB_IMM; rs1_used = 1'b0; end
      OP_AUIPC:  begin ctrl.regwrite = 1'b1; ctrl.alusrc = 1'b1; ctrl.aluop = ALU_ADD; ctrl.wb_sel = WB_ALU; rs1_used = 1'b0; end
      default:   begin ctrl.illegal = 1'b1; rs1_used = 1'b0; end
    endcase
    if (rd == '0) ctrl.regwrite = 1'b0;
  end
endmodule

// File: rtl/ctrl_pipeline.sv
// ctrl_pipeline: decoded control carried through ID/EX, EX/MEM and MEM/WB with load-use,
// redirect and memory-stall handling.
module ctrl_pipeline
  import ctrl_pkg::*;
#(
  parameter int REG_ADDR_W   = 5,
  parameter int ALUOP_W      = 2,
  parameter bit TRAP_ILLEGAL = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [6:0]            id_opcode,
  input  logic [2:0]            id_funct3,
  input  logic [6:0]            id_funct7,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  ex_redirect,
  input  logic                  mem_stall,
  output logic                  stall_if_id,
  output logic                  flush_if_id,
  output logic                  ex_valid,
  output logic                  ex_alusrc,
  output logic                  ex_branch,
  output logic                  ex_jump,
  output logic                  ex_memread,
  output logic [ALUOP_W-1:0]    ex_aluop,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  ex_illegal,
  output logic                  mem_valid,
  output logic                  mem_memread,
  output logic                  mem_memwrite,
  output logic [REG_ADDR_W-1:0] mem_rd,
  output logic                  wb_valid,
  output logic                  wb_regwrite,
  output logic [1:0]            wb_sel,
  output logic [REG_ADDR_W-1:0] wb_rd
);
  ctrl_bundle_t          dec, ex_q, ex_n;
  logic                  rs1_used, rs2_used, hazard, bubble;
  logic [REG_ADDR_W-1:0] ex_rd_n;
  logic                  mem_regwrite;
  logic [1:0]            mem_wb_sel;
  ctrl_decode #(.REG_ADDR_W(REG_ADDR_W)) u_decode (
    .opcode   (id_opcode),
    .rd       (id_rd),
    .ctrl     (dec),
    .rs1_used (rs1_used),
    .rs2_used (rs2_used)
  );
  always_comb begin
    hazard = ex_q.valid & ex_q.memread & (ex_rd != '0) & id_valid &
             ((rs1_used & (ex_rd == id_rs1)) | (rs2_used & (ex_rd == id_rs2)));
    bubble = ex_redirect | hazard | !id_valid | (dec.illegal & !TRAP_ILLEGAL);
    ex_n = bubble ? BUBBLE : dec;
    ex_rd_n = (bubble | dec.illegal) ? '0 : id_rd;
    stall_if_id = rst_n & (mem_stall | (hazard & !ex_redirect));
    flush_if_id = rst_n & !mem_stall & ex_redirect;
  end
  assign ex_valid   = ex_q.valid;
  assign ex_alusrc  = ex_q.alusrc;
  assign ex_branch  = ex_q.branch;
  assign ex_jump    = ex_q.jump;
  assign ex_memread = ex_q.memread;
  assign ex_illegal = ex_q.illegal;
  assign ex_aluop   = ALUOP_W'(ex_q.aluop);
  // the three stage registers move together; a memory stall freezes all of them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q         <= BUBBLE;
      ex_rd        <= '0;
      mem_valid    <= 1'b0;
      mem_memread  <= 1'b0;
      mem_memwrite <= 1'b0;
      mem_regwrite <= 1'b0;
      mem_wb_sel   <= '0;
      mem_rd       <= '0;
      wb_valid     <= 1'b0;
      wb_regwrite  <= 1'b0;
      wb_sel       <= '0;
      wb_rd        <= '0;
    end else if (!mem_stall) begin
      ex_q         <= ex_n;
      ex_rd        <= ex_rd_n;
      mem_valid    <= ex_q.valid;
      mem_memread  <= ex_q.memread;
      mem_memwrite <= ex_q.memwrite;
      mem_regwrite <= ex_q.regwrite;
      mem_wb_sel   <= ex_q.wb_sel;
      mem_rd       <= ex_rd;
      wb_valid     <= mem_valid;
      wb_regwrite  <= mem_regwrite;
      wb_sel       <= mem_wb_sel;
      wb_rd        <= mem_rd;
    end
  end
endmodule

// File: tb/tb_ctrl_pipeline.sv
// tb_ctrl_pipeline: directed and random stimulus on both TRAP_ILLEGAL builds against a
// behavioural model of the decode table and pipeline rules.
module tb_ctrl_pipeline;
  typedef struct packed {
    bit v, rw, as, br, jp, mr, mw, il;
    bit [1:0] op, ws;
    bit [4:0] rd;
  } st_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic id_valid = 1'b0, ex_redirect = 1'b0, mem_stall = 1'b0;
  logic [6:0] id_opcode = '0, id_funct7 = '0;
  logic [2:0] id_funct3 = '0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic stall_if_id[2], flush_if_id[2], ex_valid[2], ex_alusrc[2], ex_branch[2], ex_jump[2];
  logic ex_memread[2], ex_illegal[2], mem_valid[2], mem_memread[2], mem_memwrite[2];
  logic wb_valid[2], wb_regwrite[2];
  logic [1:0] ex_aluop[2], wb_sel[2];
  logic [4:0] ex_rd[2], mem_rd[2], wb_rd[2];
  int n_vec = 0, n_err = 0;
  st_t mex[2], mme[2], mwb[2];
  bit est[2], efl[2];
  bit [6:0] ops[9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                       7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    ctrl_pipeline #(.REG_ADDR_W(5), .ALUOP_W(2), .TRAP_ILLEGAL(g == 1)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
      .id_funct3(id_funct3), .id_funct7(id_funct7), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rd(id_rd), .ex_redirect(ex_redirect), .mem_stall(mem_stall),
      .stall_if_id(stall_if_id[g]), .flush_if_id(flush_if_id[g]), .ex_valid(ex_valid[g]),
      .ex_alusrc(ex_alusrc[g]), .ex_branch(ex_branch[g]), .ex_jump(ex_jump[g]),
      .ex_memread(ex_memread[g]), .ex_aluop(ex_aluop[g]), .ex_rd(ex_rd[g]),
      .ex_illegal(ex_illegal[g]), .mem_valid(mem_valid[g]), .mem_memread(mem_memread[g]),
      .mem_memwrite(mem_memwrite[g]), .mem_rd(mem_rd[g]), .wb_valid(wb_valid[g]),
      .wb_regwrite(wb_regwrite[g]), .wb_sel(wb_sel[g]), .wb_rd(wb_rd[g])
    );
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask
  // decode table straight from the instruction-format list; rd = 0 never writes
  function automatic void spec_dec(input bit [6:0] opc, input bit [4:0] rd,
                                   output st_t s, output bit r1, output bit r2);
    s = '0; s.v = 1; s.rd = rd; r1 = 1; r2 = 0;
    case (opc)
      7'b0110011: begin s.rw = 1; s.op = 2; r2 = 1; end
      7'b0010011: begin s.rw = 1; s.as = 1; s.op = 3; end
      7'b0000011: begin s.rw = 1; s.as = 1; s.mr = 1; s.ws = 1; end
      7'b0100011: begin s.as = 1; s.mw = 1; r2 = 1; end
      7'b1100011: begin s.br = 1; s.op = 1; r2 = 1; end
      7'b1101111: begin s.rw = 1; s.jp = 1; s.ws = 2; r1 = 0; end
      7'b1100111: begin s.rw = 1; s.jp = 1; s.as = 1; s.ws = 2; end
      7'b0110111: begin s.rw = 1; s.as = 1; s.ws = 3; r1 = 0; end
      7'b0010111: begin s.rw = 1; s.as = 1; r1 = 0; end
      default:    begin s.il = 1; s.rd = 0; r1 = 0; end
    endcase
    if (rd == 0) s.rw = 0;
  endfunction
  task automatic check_all();
    for (int t = 0; t < 2; t++) begin
      chk($sformatf("comb_t%0d", t), {30'd0, stall_if_id[t], flush_if_id[t]}, {30'd0, est[t], efl[t]});
      chk($sformatf("ex_t%0d", t),
          {ex_valid[t], ex_alusrc[t], ex_branch[t], ex_jump[t], ex_memread[t], ex_illegal[t], ex_aluop[t], ex_rd[t]},
          {mex[t].v, mex[t].as, mex[t].br, mex[t].jp, mex[t].mr, mex[t].il, mex[t].op, mex[t].rd});
      chk($sformatf("mem_t%0d", t), {mem_valid[t], mem_memread[t], mem_memwrite[t], mem_rd[t]},
          {mme[t].v, mme[t].mr, mme[t].mw, mme[t].rd});
      chk($sformatf("wb_t%0d", t), {wb_valid[t], wb_regwrite[t], wb_sel[t], wb_rd[t]},
          {mwb[t].v, mwb[t].rw, mwb[t].ws, mwb[t].rd});
    end
  endtask
  task automatic model_reset();
    for (int t = 0; t < 2; t++) begin
      mex[t] = '0; mme[t] = '0; mwb[t] = '0; est[t] = 0; efl[t] = 0;
    end
  endtask
  // one clock: drive just after a rising edge, check at the falling edge, advance the model
  task automatic cyc(input bit v, input bit [6:0] opc, input bit [4:0] rd, input bit [4:0] rs1,
                     input bit [4:0] rs2, input bit rdr, input bit ms);
    st_t s, nex[2];
    bit r1, r2, haz;
    id_valid = v; id_opcode = opc; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    ex_redirect = rdr; mem_stall = ms;
    id_funct3 = 3'($urandom); id_funct7 = 7'($urandom);
    spec_dec(opc, rd, s, r1, r2);
    for (int t = 0; t < 2; t++) begin
      haz = mex[t].v && mex[t].mr && mex[t].rd != 0 && v &&
            ((r1 && mex[t].rd == rs1) || (r2 && mex[t].rd == rs2));
      est[t] = ms || (haz && !rdr);
      efl[t] = !ms && rdr;
      nex[t] = (rdr || haz || !v || (s.il && t == 0)) ? '0 : s;
    end
    @(negedge clk);
    check_all();
    @(posedge clk);
    #1;
    if (!ms)
      for (int t = 0; t < 2; t++) begin
        mwb[t] = mme[t]; mme[t] = mex[t]; mex[t] = nex[t];
      end
  endtask
  initial begin
    bit v, rdr, ms, hold;
    bit [6:0] opc;
    bit [4:0] rd, rs1, rs2;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 9; i++) cyc(1, ops[i], 5'd5, 5'd1, 5'd2, 0, 0);
    repeat (3) cyc(0, 7'd0, 5'd0, 5'd0, 5'd0, 0, 0);
    cyc(1, 7'b0000011, 5'd7, 5'd1, 5'd0, 0, 0);
    repeat (2) cyc(1, 7'b0110011, 5'd8, 5'd7, 5'd2, 0, 0);
    cyc(1, 7'b0000011, 5'd7, 5'd1, 5'd0, 0, 0);
    cyc(1, 7'b0110111, 5'd3, 5'd7, 5'd7, 0, 0);
    cyc(1, 7'b0000011, 5'd0, 5'd1, 5'd0, 0, 0);
    cyc(1, 7'b0110011, 5'd9, 5'd0, 5'd0, 0, 0);
    repeat (3) cyc(0, 7'd0, 5'd0, 5'd0, 5'd0, 0, 0);
    cyc(1, 7'b0100011, 5'd0, 5'd1, 5'd2, 1, 0);
    repeat (3) cyc(0, 7'd0, 5'd0, 5'd0, 5'd0, 0, 0);
    cyc(1, 7'b0000011, 5'd7, 5'd1, 5'd0, 0, 0);
    cyc(1, 7'b0110011, 5'd8, 5'd7, 5'd2, 1, 0);
    for (int i = 0; i < 4; i++) cyc(1, ops[i], 5'(10 + i), 5'd1, 5'd2, 0, 0);
    repeat (3) cyc(1, ops[4], 5'd14, 5'd1, 5'd2, 0, 1);
    for (int i = 4; i < 9; i++) cyc(1, ops[i], 5'(10 + i), 5'd1, 5'd2, 0, 0);
    cyc(1, 7'b1111111, 5'd6, 5'd1, 5'd2, 0, 0);
    repeat (3) cyc(0, 7'd0, 5'd0, 5'd0, 5'd0, 0, 0);
    hold = 0;
    for (int i = 0; i < 600; i++) begin
      if (!hold) begin
        v = $urandom_range(9, 0) != 0;
        opc = ops[$urandom_range(8, 0)];
        rd = 5'($urandom_range(7, 0)); rs1 = 5'($urandom_range(7, 0)); rs2 = 5'($urandom_range(7, 0));
      end
      rdr = $urandom_range(9, 0) == 0;
      ms = $urandom_range(6, 0) == 0;
      cyc(v, opc, rd, rs1, rs2, rdr, ms);
      hold = est[1] && !efl[1];
    end
    cyc(1, 7'b0110011, 5'd4, 5'd1, 5'd2, 0, 0);
    cyc(1, 7'b0000011, 5'd5, 5'd1, 5'd2, 0, 0);
    id_valid = 1; id_opcode = 7'b0110011; id_rs1 = 5'd5; mem_stall = 1;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc(1, 7'b0010011, 5'd6, 5'd1, 5'd2, 0, 0);
    repeat (3) cyc(0, 7'd0, 5'd0, 5'd0, 5'd0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
